// File: rtl/npu_host_ctrl_if.sv
// Host access bus (block-RAM style enable/strobe/address/data) for npu_host_ctrl.
interface npu_host_ctrl_if #(
   parameter int BW = 32
);
   logic          ena;
   logic          wea;
   logic [15:0]   addra;
   logic [BW-1:0] dina;
   logic [BW-1:0] douta;

   modport master (output ena, wea, addra, dina, input douta);
   modport slave  (input ena, wea, addra, dina, output douta);
endinterface

// File: rtl/npu_host_ctrl.sv
// Host-side controller for the NPU: register map, FC1 weight FIFO and the
// IDLE -> CONV -> FCN run sequencer with status flags and interrupt.
module npu_host_ctrl #(
   parameter int  NUM_PE   = 4,
   parameter int  WF_DEPTH = 8,
   parameter int  ACC_W    = 24,
   localparam int BW       = 8 * NUM_PE
) (
   input  logic             clk,
   input  logic             rst,
   npu_host_ctrl_if.slave   host,
   output logic             conv_start,
   input  logic             conv_done,
   output logic             fcn_start,
   input  logic             fcn_done,
   input  logic [ACC_W-1:0] fcn_logit,
   output logic [BW-1:0]    fc1_w,
   output logic             fc1_w_valid,
   input  logic             fc1_w_ready,
   output logic             irq
);

   localparam int            PW       = $clog2(WF_DEPTH);
   localparam int            LW       = PW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(WF_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_FCN  = 2'd2
   } state_t;

   state_t           r_state;
   logic [BW-1:0]    r_mem [WF_DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             r_done;
   logic             r_ovf;
   logic             r_udf;
   logic             r_bsy;
   logic             r_irq_en;
   logic [ACC_W-1:0] r_result;
   logic             r_conv_start;
   logic             r_fcn_start;

   logic [2:0]       w_sel;
   logic [11:0]      w_idx;
   logic             w_unused;
   logic             w_wr;
   logic             w_rd;
   logic             w_ctl;
   logic             w_start;
   logic             w_w1c;
   logic             w_abort;
   logic             w_irqen_wr;
   logic [3:0]       w_clr;
   logic             w_empty;
   logic             w_full;
   logic             w_in_fcn;
   logic             w_valid;
   logic             w_pop;
   logic             w_push_req;
   logic             w_push;
   logic             w_ovf_set;
   logic             w_udf_set;
   logic             w_bsy_set;
   logic             w_start_ok;
   logic             w_conv_ev;
   logic             w_done_ev;
   logic [BW-1:0]    w_res_ext;
   logic [BW-1:0]    w_douta;

   assign w_sel      = host.addra[14:12];
   assign w_idx      = host.addra[11:0];
   assign w_unused   = host.addra[15];
   assign w_wr       = host.ena & host.wea;
   assign w_rd       = host.ena & ~host.wea;
   assign w_ctl      = w_wr & (w_sel == 3'b101);
   assign w_start    = w_ctl & (w_idx == 12'd1);
   assign w_w1c      = w_ctl & (w_idx == 12'd2);
   assign w_abort    = w_ctl & (w_idx == 12'd3);
   assign w_irqen_wr = w_ctl & (w_idx == 12'd4);
   assign w_clr      = w_w1c ? host.dina[3:0] : 4'b0000;

   assign w_empty    = (r_level == {LW{1'b0}});
   assign w_full     = (r_level == FULL_LVL);
   assign w_in_fcn   = (r_state == ST_FCN);
   assign w_valid    = ~w_empty & w_in_fcn;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_pop      = w_valid & fc1_w_ready & ~w_abort;
   assign w_push_req = w_wr & (w_sel == 3'b011) & ~w_abort;
   assign w_push     = w_push_req & (~w_full | w_pop);
   assign w_ovf_set  = w_push_req & w_full & ~w_pop;
   assign w_udf_set  = w_in_fcn & w_empty & fc1_w_ready;
   assign w_bsy_set  = w_start & (r_state != ST_IDLE);
   assign w_start_ok = w_start & (r_state == ST_IDLE);
   assign w_conv_ev  = conv_done & (r_state == ST_CONV) & ~w_abort;
   assign w_done_ev  = fcn_done & w_in_fcn & ~w_abort;
   assign w_res_ext  = BW'($signed(r_result));

   // Host read-back mux; everything outside the status window reads as zero.
   always_comb begin
      w_douta = {BW{1'b0}};
      if (w_rd && (w_sel == 3'b111)) begin
         case (w_idx)
            12'd0:   w_douta = BW'(r_done);
            12'd4:   w_douta = w_res_ext;
            12'd8:   w_douta = BW'(r_level);
            12'd12:  w_douta = BW'({r_bsy, r_udf, r_ovf});
            12'd16:  w_douta = BW'(r_state);
            12'd20:  w_douta = BW'(r_irq_en);
            default: w_douta = {BW{1'b0}};
         endcase
      end else begin
         w_douta = {BW{1'b0}};
      end
   end

   // Weight FIFO storage, pointers and fill level; abort flushes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WF_DEPTH; i++) begin
            r_mem[i] <= {BW{1'b0}};
         end
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_level  <= {LW{1'b0}};
      end else if (w_abort) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_level  <= {LW{1'b0}};
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= host.dina;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Run sequencer with registered start pulses and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_conv_start <= 1'b0;
         r_fcn_start  <= 1'b0;
         r_result     <= {ACC_W{1'b0}};
      end else begin
         r_conv_start <= 1'b0;
         r_fcn_start  <= 1'b0;
         if (w_abort) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_start_ok) begin
                     r_state      <= ST_CONV;
                     r_conv_start <= 1'b1;
                  end
               end
               ST_CONV: begin
                  if (w_conv_ev) begin
                     r_state     <= ST_FCN;
                     r_fcn_start <= 1'b1;
                  end
               end
               ST_FCN: begin
                  if (w_done_ev) begin
                     r_state  <= ST_IDLE;
                     r_result <= fcn_logit;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   // Sticky status flags; a host clear beats a same-cycle set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
         r_bsy    <= 1'b0;
         r_done   <= 1'b0;
         r_irq_en <= 1'b0;
      end else begin
         r_ovf <= (r_ovf | w_ovf_set) & ~w_clr[0];
         r_udf <= (r_udf | w_udf_set) & ~w_clr[1];
         r_bsy <= (r_bsy | w_bsy_set) & ~w_clr[2];
         if (w_clr[3]) begin
            r_done <= 1'b0;
         end else if (w_done_ev) begin
            r_done <= 1'b1;
         end else if (w_start_ok) begin
            r_done <= 1'b0;
         end else begin
            r_done <= r_done;
         end
         if (w_irqen_wr) begin
            r_irq_en <= host.dina[0];
         end
      end
   end

   assign host.douta  = w_douta;
   assign conv_start  = r_conv_start;
   assign fcn_start   = r_fcn_start;
   assign fc1_w       = w_empty ? {BW{1'b0}} : r_mem[r_rd_ptr];
   assign fc1_w_valid = w_valid;
   assign irq         = r_done & r_irq_en;

endmodule

// File: doc/npu_host_ctrl.md
NPU_HOST_CTRL -- requirements
Module: npu_host_ctrl

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, meaning PE lanes; legal values 4, 8, 16; bus width BW = 8*NUM_PE.
REQ-002 SHALL have parameter WF_DEPTH, default 8, meaning FC1 weight FIFO depth in groups; power of two, at least 2.
REQ-003 SHALL have parameter ACC_W, default 24, meaning logit width; at most 32.
REQ-004 SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-006 SHALL have port ena, input, width 1: host access enable.
REQ-007 SHALL have port wea, input, width 1: host write strobe; a write = ena&wea, a read = ena&~wea.
REQ-008 SHALL have port addra, input, width 16: sel=addra[14:12], idx=addra[11:0].
REQ-009 SHALL have port dina, input, width BW: host write data.
REQ-010 SHALL have port douta, output, width BW: combinational read data.
REQ-011 SHALL have port conv_start, output, width 1: one-cycle pulse that starts the conv engine.
REQ-012 SHALL have port conv_done, input, width 1: conv completion pulse.
REQ-013 SHALL have port fcn_start, output, width 1: one-cycle pulse that starts the FCN engine.
REQ-014 SHALL have port fcn_done, input, width 1: FCN completion pulse.
REQ-015 SHALL have port fcn_logit, input, width ACC_W: signed result, valid with fcn_done.
REQ-016 SHALL have port fc1_w, output, width BW: weight group at the FIFO head; lane p = bits [8p+7:8p].
REQ-017 SHALL have port fc1_w_valid, output, width 1: FIFO not empty and state == FCN.
REQ-018 SHALL have port fc1_w_ready, input, width 1: engine accepts the head group.
REQ-019 SHALL have port irq, output, width 1: level interrupt = done & irq_en.

Function
REQ-020 SHALL treat a write with sel=3'b011 as a FIFO push of dina; if full and no pop occurs that cycle, the push SHALL be dropped and flag OVF set.
REQ-021 SHALL pop one group on each cycle where fc1_w_valid & fc1_w_ready; a push and a pop in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-022 SHALL set flag UDF on each cycle where state == FCN, the FIFO is empty and fc1_w_ready = 1.
REQ-023 SHALL use pointer wrap modulo WF_DEPTH and keep the level in range 0..WF_DEPTH.
REQ-024 SHALL implement FSM states IDLE, CONV, FCN.
REQ-025 SHALL, on a write with sel=3'b101, idx=1 in IDLE: pulse conv_start on the next cycle, clear done, enter CONV.
REQ-026 SHALL, on a write with sel=3'b101, idx=1 outside IDLE, ignore the start and set flag BSY.
REQ-027 SHALL, in CONV on conv_done, pulse fcn_start on the next cycle and enter FCN.
REQ-028 SHALL, in FCN on fcn_done: latch fcn_logit into result, set done, enter IDLE.
REQ-029 SHALL, on a write with sel=3'b101, idx=3 (abort): enter IDLE from any state, flush the FIFO, leave done unchanged, issue no pulses; abort SHALL have priority over any same-cycle start, push or done event.
REQ-030 SHALL treat a write with sel=3'b101, idx=2 as write-1-to-clear: dina[0] clears OVF, [1] clears UDF, [2] clears BSY, [3] clears done; a clear SHALL have priority over a same-cycle set.
REQ-031 SHALL treat a write with sel=3'b101, idx=4 as irq_en <= dina[0].
REQ-032 SHALL drive douta = 0 unless a read with sel=3'b111 selects one of:
- idx 0: {done}
- idx 4: result sign-extended to BW
- idx 8: FIFO level
- idx 12: {BSY,UDF,OVF}
- idx 16: state code (IDLE=0, CONV=1, FCN=2)
- idx 20: irq_en
REQ-033 SHALL ignore writes to unmapped sel/idx values, with no side effects.
REQ-034 SHALL ignore conv_done outside CONV and fcn_done outside FCN.

Reset
REQ-035 SHALL, while rst = 1, hold: state IDLE, FIFO empty, done, OVF, UDF, BSY, irq_en, result, conv_start, fcn_start = 0, fc1_w = 0, fc1_w_valid = 0, irq = 0.
REQ-036 SHALL abandon any in-flight run when reset is asserted mid-operation; no pulse SHALL follow reset release.

Verification
REQ-037 Happy path, NUM_PE=4: push 3 groups, start, conv_done, ready=1 for 3 cycles, fcn_done with logit=-5 -> one conv_start and one fcn_start pulse; groups pop in order; idx4 reads 0xFFFFFFFB; done=1.
REQ-038 FIFO full, WF_DEPTH=8: 9 pushes -> level 8, OVF=1; then a push and a pop in the same cycle -> level stays 8, OVF unchanged.
REQ-039 Start while in CONV -> BSY=1, no second conv_start; writing idx2 with dina=4 -> BSY=0.
REQ-040 Abort in FCN with 5 groups queued -> state 0, level 0, fc1_w_valid=0; a late fcn_done is ignored and done stays 0.
REQ-041 irq_en=1, then complete a run -> irq=1; clear done (idx2, dina=8) -> irq=0 the next cycle.
REQ-042 Assert rst mid-CONV with 2 groups queued -> every output and register at its REQ-035 value; conv_done after release -> no fcn_start.
